rr_arbiter_16: RTL and testbench

- 16-requester round-robin arbiter that shares one resource between ingress ports, e.g. an SRAM write port or a free-page allocator.
- Grants are packet-locked: one owner holds the resource until its last beat is accepted.
- Drives the same 5-bit index encoding used across the design: 0..15 is the owner, 16 means no owner.
- Sits between the per-port request logic and the shared resource mux.

---
 rtl/rr_arbiter_16.sv | 166 ++++++++++++++++
 tb/tb_rr_arbiter_16.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_16.sv
// 16-requester packet-locked round-robin arbiter with a 5-bit owner index (16 = no owner).
// Optional grant hold limit is built only when ARB_HOLD_LIMIT_EN is defined.
module rr_arbiter_16 #(
    parameter int unsigned NUM_REQ  = 16,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic               res_ready,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld,
    output logic               hold_expired
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] IdxNone = IDX_W'(NUM_REQ);

    // The index encoding reserves value NUM_REQ for "none", so the sizes are locked together.
    if (NUM_REQ != 16 || IDX_W != 5 || MAX_HOLD < 2) begin : g_bad_cfg
        $error("rr_arbiter_16: unsupported parameter set");
    end

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;

    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   owner_nxt;
    logic [PTR_W-1:0]   arb_ptr;
    logic [IDX_W-1:0]   win_idx;
    logic               beat;
    logic               norm_rel;
    logic               force_rel;
    logic               rel;
    logic               load;

    // First set bit of r scanning p, p+1, ... wrapping; IdxNone when r is empty.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [PTR_W-1:0]   p);
        logic [PTR_W-1:0] c;
        rr_pick = IdxNone;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            c = p + PTR_W'(i);
            if (r[c]) begin
                rr_pick = {1'b0, c};
            end
        end
    endfunction

    assign owner     = idx_q[PTR_W-1:0];
    assign owner_nxt = owner + PTR_W'(1);
    assign beat      = gnt_vld & res_ready;
    assign norm_rel  = (beat & last[owner]) | ~req[owner];

    // On release the new winner is chosen from the already-advanced pointer.
    assign arb_ptr   = (state_q == StGrant) ? owner_nxt : ptr_q;
    assign win_idx   = rr_pick(req, arb_ptr);
    assign rel       = (state_q == StGrant) & (norm_rel | force_rel);

`ifdef ARB_HOLD_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             expired_q;

    // A normal release in the limit cycle wins, so force_rel excludes it.
    assign force_rel = (state_q == StGrant) & (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) & ~norm_rel;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (load || state_d == StIdle) begin
            hold_cnt_d = '0;
        end else if (state_q == StGrant) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
            expired_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            expired_q  <= force_rel;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            idx_q   <= IdxNone;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_idx != IdxNone) begin
                    load    = 1'b1;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (rel) begin
                    ptr_d = owner_nxt;
                    if (win_idx != IdxNone) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                        idx_d   = IdxNone;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (load) begin
            gnt_d = NUM_REQ'(1) << win_idx[PTR_W-1:0];
            idx_d = win_idx;
        end
    end

    // Output logic.
    always_comb begin
        gnt     = gnt_q;
        gnt_idx = idx_q;
        gnt_vld = (state_q == StGrant);
`ifdef ARB_HOLD_LIMIT_EN
        hold_expired = expired_q;
`else
        hold_expired = 1'b0;
`endif
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_idx_vld: assert property (@(posedge clk) disable iff (rst)
                                gnt_vld == (gnt_idx != IdxNone));
    a_vld_gnt: assert property (@(posedge clk) disable iff (rst) gnt_vld == (|gnt));

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Scoreboard bench for rr_arbiter_16: expected owner/pulse pushed per driven cycle, popped after
// the edge. Hold-limit scenarios follow ARB_HOLD_LIMIT_EN (bench sets MAX_HOLD=8).
module tb_rr_arbiter_16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [15:0] last;
    logic        res_ready;
    logic [15:0] gnt;
    logic [4:0]  gnt_idx;
    logic        gnt_vld;
    logic        hold_expired;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic [15:0] last;
        logic        rdy;
        logic [4:0]  idx;
        logic        he;
    } step_t;

    typedef struct {
        logic [4:0] idx;
        logic       he;
        int         step;
    } exp_t;

    exp_t sb[$];

`ifdef ARB_HOLD_LIMIT_EN
    localparam int BP = 6;
`else
    localparam int BP = 10;
`endif

    rr_arbiter_16 #(
        .NUM_REQ (16),
        .IDX_W   (5),
        .MAX_HOLD(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .last        (last),
        .res_ready   (res_ready),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_vld     (gnt_vld),
        .hold_expired(hold_expired)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(input logic r, input logic [15:0] q, input logic [15:0] l,
                                 input logic y, input logic [4:0] i, input logic h);
        step_t s;
        s.rst = r; s.req = q; s.last = l; s.rdy = y; s.idx = i; s.he = h;
        return s;
    endfunction

    function automatic logic [15:0] onehot_of(input logic [4:0] i);
        logic [15:0] one;
        one = 16'h0001;
        return (i == 5'd16) ? 16'h0000 : (one << i[3:0]);
    endfunction

    task automatic drive_edge(input step_t s);
        rst       = s.rst;
        req       = s.req;
        last      = s.last;
        res_ready = s.rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 16'h0000, 16'h0000, 1, 16, 0));
        st.push_back(mk(1, 16'h0000, 16'h0000, 1, 16, 0));
        st.push_back(mk(0, 16'h0000, 16'h0000, 1, 16, 0));
        st.push_back(mk(0, 16'h0000, 16'h0000, 1, 16, 0));
        st.push_back(mk(0, 16'h0010, 16'h0000, 1, 4, 0));
        st.push_back(mk(1, 16'h0010, 16'h0000, 1, 16, 0));   // reset mid-packet
        st.push_back(mk(0, 16'h0010, 16'h0000, 0, 4, 0));
        st.push_back(mk(0, 16'h0000, 16'h0000, 0, 16, 0));
        for (int k = 0; k < st.size(); k++) begin
            sb.push_back('{idx: st[k].idx, he: st[k].he, step: k});
            drive_edge(st[k]);
            e = sb.pop_front();
            total++;
            if (gnt_idx !== e.idx || gnt !== onehot_of(e.idx) ||
                gnt_vld !== (e.idx != 5'd16) || hold_expired !== e.he) begin
                bad++;
                $display("FAIL reset step %0d: got idx=%0d gnt=%h vld=%b he=%b, want idx=%0d he=%b",
                         e.step, gnt_idx, gnt, gnt_vld, hold_expired, e.idx, e.he);
            end
        end
    endtask

    task automatic test_single_packet();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 16'h0000, 16'h0000, 1, 16, 0));
        st.push_back(mk(0, 16'h0008, 16'h0000, 1, 3, 0));
        st.push_back(mk(0, 16'h0008, 16'h0000, 1, 3, 0));    // beat 1
        st.push_back(mk(0, 16'h0008, 16'h0000, 1, 3, 0));
        st.push_back(mk(0, 16'h0008, 16'h0000, 1, 3, 0));
        st.push_back(mk(0, 16'h0000, 16'h0008, 1, 16, 0));   // beat 4 with last
        st.push_back(mk(0, 16'h0018, 16'h0000, 1, 4, 0));    // ptr now 4
        st.push_back(mk(0, 16'h0000, 16'h0000, 1, 16, 0));
        for (int k = 0; k < st.size(); k++) begin
            sb.push_back('{idx: st[k].idx, he: st[k].he, step: k});
            drive_edge(st[k]);
            e = sb.pop_front();
            total++;
            if (gnt_idx !== e.idx || gnt !== onehot_of(e.idx) ||
                gnt_vld !== (e.idx != 5'd16) || hold_expired !== e.he) begin
                bad++;
                $display("FAIL single step %0d: got idx=%0d gnt=%h vld=%b he=%b, want idx=%0d he=%b",
                         e.step, gnt_idx, gnt, gnt_vld, hold_expired, e.idx, e.he);
            end
        end
    endtask

    task automatic test_rotation();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 16'h0000, 16'h0000, 1, 16, 0));
        for (int i = 0; i <= 16; i++) begin
            st.push_back(mk(0, 16'hFFFF, 16'hFFFF, 1, 5'(i % 16), 0));
        end
        st.push_back(mk(0, 16'h0001, 16'h0000, 0, 0, 0));    // no beat: owner 0 kept
        st.push_back(mk(0, 16'h0001, 16'h0001, 1, 0, 0));    // sole requester wins again
        st.push_back(mk(0, 16'h0000, 16'h0000, 1, 16, 0));
        for (int k = 0; k < st.size(); k++) begin
            sb.push_back('{idx: st[k].idx, he: st[k].he, step: k});
            drive_edge(st[k]);
            e = sb.pop_front();
            total++;
            if (gnt_idx !== e.idx || gnt !== onehot_of(e.idx) ||
                gnt_vld !== (e.idx != 5'd16) || hold_expired !== e.he) begin
                bad++;
                $display("FAIL rotation step %0d: got idx=%0d gnt=%h vld=%b he=%b, want idx=%0d he=%b",
                         e.step, gnt_idx, gnt, gnt_vld, hold_expired, e.idx, e.he);
            end
        end
    endtask

    task automatic test_wrap_sparse();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 16'h0000, 16'h0000, 1, 16, 0));
        st.push_back(mk(0, 16'h2000, 16'h0000, 1, 13, 0));
        st.push_back(mk(0, 16'h0000, 16'h0000, 1, 16, 0));   // abort 13: ptr=14
        st.push_back(mk(0, 16'h0204, 16'h0000, 1, 2, 0));
        st.push_back(mk(0, 16'h0204, 16'h0004, 1, 9, 0));    // 2 still requesting, 9 is next
        st.push_back(mk(0, 16'h0000, 16'h0200, 1, 16, 0));
        for (int k = 0; k < st.size(); k++) begin
            sb.push_back('{idx: st[k].idx, he: st[k].he, step: k});
            drive_edge(st[k]);
            e = sb.pop_front();
            total++;
            if (gnt_idx !== e.idx || gnt !== onehot_of(e.idx) ||
                gnt_vld !== (e.idx != 5'd16) || hold_expired !== e.he) begin
                bad++;
                $display("FAIL wrap step %0d: got idx=%0d gnt=%h vld=%b he=%b, want idx=%0d he=%b",
                         e.step, gnt_idx, gnt, gnt_vld, hold_expired, e.idx, e.he);
            end
        end
    endtask

    task automatic test_abort_backpressure();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 16'h0000, 16'h0000, 0, 16, 0));
        st.push_back(mk(0, 16'h0020, 16'h0000, 0, 5, 0));
        for (int i = 0; i < BP; i++) begin
            st.push_back(mk(0, 16'h00A0, 16'h0020, 0, 5, 0));
        end
        st.push_back(mk(0, 16'h0080, 16'h0000, 0, 7, 0));
        st.push_back(mk(0, 16'h0000, 16'h0000, 0, 16, 0));
        for (int k = 0; k < st.size(); k++) begin
            sb.push_back('{idx: st[k].idx, he: st[k].he, step: k});
            drive_edge(st[k]);
            e = sb.pop_front();
            total++;
            if (gnt_idx !== e.idx || gnt !== onehot_of(e.idx) ||
                gnt_vld !== (e.idx != 5'd16) || hold_expired !== e.he) begin
                bad++;
                $display("FAIL abort step %0d: got idx=%0d gnt=%h vld=%b he=%b, want idx=%0d he=%b",
                         e.step, gnt_idx, gnt, gnt_vld, hold_expired, e.idx, e.he);
            end
        end
    endtask

    task automatic test_hold_limit();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 16'h0000, 16'h0000, 1, 16, 0));
        st.push_back(mk(0, 16'h0006, 16'h0000, 1, 1, 0));
`ifdef ARB_HOLD_LIMIT_EN
        for (int i = 0; i < 7; i++) begin
            st.push_back(mk(0, 16'h0006, 16'h0000, 1, 1, 0));
        end
        st.push_back(mk(0, 16'h0006, 16'h0000, 1, 2, 1));    // forced out after 8 cycles
        st.push_back(mk(0, 16'h0006, 16'h0000, 1, 2, 0));
        st.push_back(mk(0, 16'h0000, 16'h0000, 1, 16, 0));
        // Normal release in the limit cycle takes precedence.
        st.push_back(mk(1, 16'h0000, 16'h0000, 1, 16, 0));
        st.push_back(mk(0, 16'h0002, 16'h0000, 1, 1, 0));
        for (int i = 0; i < 7; i++) begin
            st.push_back(mk(0, 16'h0002, 16'h0000, 1, 1, 0));
        end
        st.push_back(mk(0, 16'h0002, 16'h0002, 1, 1, 0));
        st.push_back(mk(0, 16'h0002, 16'h0000, 1, 1, 0));
        st.push_back(mk(0, 16'h0000, 16'h0000, 1, 16, 0));
`else
        for (int i = 0; i < 20; i++) begin
            st.push_back(mk(0, 16'h0006, 16'h0000, 1, 1, 0));
        end
        st.push_back(mk(0, 16'h0004, 16'h0000, 1, 2, 0));
        st.push_back(mk(0, 16'h0000, 16'h0000, 1, 16, 0));
`endif
        for (int k = 0; k < st.size(); k++) begin
            sb.push_back('{idx: st[k].idx, he: st[k].he, step: k});
            drive_edge(st[k]);
            e = sb.pop_front();
            total++;
            if (gnt_idx !== e.idx || gnt !== onehot_of(e.idx) ||
                gnt_vld !== (e.idx != 5'd16) || hold_expired !== e.he) begin
                bad++;
                $display("FAIL hold step %0d: got idx=%0d gnt=%h vld=%b he=%b, want idx=%0d he=%b",
                         e.step, gnt_idx, gnt, gnt_vld, hold_expired, e.idx, e.he);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        last      = '0;
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_packet();
        test_rotation();
        test_wrap_sparse();
        test_abort_backpressure();
        test_hold_limit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
